alu_sequencer: RTL and testbench

- Command-driven controller that sequences the 8-bit two-operand ALU (2-bit select: 00 ADD, 01 SUB, 10 AND, 11 OR; combinational result and zero flag).
- Owns a 4-entry x 8-bit register file and accepts one command at a time over a valid/ready interface.
- For each command it fetches operands, drives the ALU, writes the result back and returns a response over a valid/ready interface.
- Sits between the instruction/control front end and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 44 ++++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-side signals of alu_sequencer.
// master = front end plus ALU instance, slave = the sequencer.
interface alu_sequencer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [1:0]        cmd_rd;
    logic [1:0]        cmd_rs1;
    logic [1:0]        cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic              flag_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  alu_x, alu_y, alu_sel,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_data, rsp_zero, rsp_err, flag_zero,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output alu_x, alu_y, alu_sel,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_data, rsp_zero, rsp_err, flag_zero,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences an external 8-bit ALU over a 4-entry register file: accepts one command,
// fetches operands, writes the result back and returns a response.
module alu_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4
) (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);
    localparam int unsigned AddrW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {StIdle, StOper, StExec, StResp} state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [AddrW-1:0]  r_rd;
    logic              r_cmd_ready;
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    logic [1:0]        r_alu_sel;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_err;
    logic              r_flag_zero;

    logic              w_accept;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    assign w_accept  = bus.cmd_valid && r_cmd_ready;
    assign w_rs1_val = r_regs[bus.cmd_rs1];
    assign w_rs2_val = r_regs[bus.cmd_rs2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rd        <= '0;
            r_cmd_ready <= 1'b1;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_flag_zero <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_rd        <= bus.cmd_rd;
                        if (!bus.cmd_op[2]) begin
                            // Operands are read here, before any writeback to rd.
                            r_alu_x   <= w_rs1_val;
                            r_alu_y   <= w_rs2_val;
                            r_alu_sel <= bus.cmd_op[1:0];
                            r_state   <= StOper;
                        end else begin
                            r_state <= StResp;
                            case (bus.cmd_op[1:0])
                                2'b00: begin
                                    r_regs[bus.cmd_rd] <= bus.cmd_imm;
                                    r_rsp_data         <= bus.cmd_imm;
                                    r_rsp_zero         <= (bus.cmd_imm == '0);
                                end
                                2'b01: begin
                                    r_rsp_data <= w_rs1_val;
                                    r_rsp_zero <= (w_rs1_val == '0);
                                end
                                default: begin
                                    r_rsp_err  <= 1'b1;
                                    r_rsp_data <= '0;
                                    r_rsp_zero <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                StOper: begin
                    r_state <= StExec;
                end
                StExec: begin
                    r_regs[r_rd] <= bus.alu_result;
                    r_rsp_data   <= bus.alu_result;
                    r_rsp_zero   <= bus.alu_zero;
                    r_flag_zero  <= bus.alu_zero;
                    r_state      <= StResp;
                end
                StResp: begin
                    // rsp_valid rises one cycle after entering RESP, once the response
                    // registers have been loaded; rsp_ready is ignored until then.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.alu_x     = r_alu_x;
    assign bus.alu_y     = r_alu_y;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.flag_zero = r_flag_zero;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: a queue-based command/response model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_alu_sequencer;
    typedef struct {
        int         lat;
        int         acc;
        logic [7:0] data;
        logic       zero;
        logic       err;
        logic       flag;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    logic chk_en;
    logic hold;
    logic force_rdy;

    exp_t       q[$];
    logic [7:0] m_regs [4];
    logic       m_flag;
    logic [7:0] m_ax;
    logic [7:0] m_ay;
    logic [1:0] m_as;
    logic [7:0] last_data;
    logic       last_zero;
    logic       last_err;
    logic [7:0] alu_r;
    int         cmp_k;
    logic       cmp_v;

    alu_sequencer_if #(.DATA_W(8)) bif ();

    alu_sequencer #(
        .DATA_W  (8),
        .NUM_REGS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    // ALU instance stand-in: 00 ADD, 01 SUB, 10 AND, 11 OR.
    always_comb begin
        alu_r = 8'h00;
        case (bif.alu_sel)
            2'b00:   alu_r = bif.alu_x + bif.alu_y;
            2'b01:   alu_r = bif.alu_x - bif.alu_y;
            2'b10:   alu_r = bif.alu_x & bif.alu_y;
            default: alu_r = bif.alu_x | bif.alu_y;
        endcase
    end
    assign bif.alu_result = alu_r;
    assign bif.alu_zero   = (alu_r == 8'h00);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        bif.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold) bif.rsp_ready = 1'b0;
            else if (force_rdy) bif.rsp_ready = 1'b1;
            else bif.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flag = 1'b0;
        m_ax   = 8'h00;
        m_ay   = 8'h00;
        m_as   = 2'b00;
    endtask

    // Every cycle: cmd_ready/rsp_valid timing, response contents, flag and ALU operands.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                if (q.size() == 0) begin
                    check("idle_cmd_ready", bif.cmd_ready, 1);
                    check("idle_rsp_valid", bif.rsp_valid, 0);
                    check("idle_rsp_err", bif.rsp_err, 0);
                    check("idle_flag_zero", bif.flag_zero, m_flag);
                end else begin
                    cmp_k = cyc - q[0].acc;
                    cmp_v = (cmp_k >= q[0].lat);
                    check("busy_cmd_ready", bif.cmd_ready, 0);
                    check("rsp_valid_timing", bif.rsp_valid, cmp_v);
                    if (cmp_v) begin
                        check("rsp_data", bif.rsp_data, q[0].data);
                        check("rsp_zero", bif.rsp_zero, q[0].zero);
                        check("rsp_err", bif.rsp_err, q[0].err);
                        check("rsp_flag_zero", bif.flag_zero, q[0].flag);
                        if (bif.rsp_ready) begin
                            last_data = bif.rsp_data;
                            last_zero = bif.rsp_zero;
                            last_err  = bif.rsp_err;
                            q.delete(0);
                        end
                    end
                end
                check("alu_x", bif.alu_x, m_ax);
                check("alu_y", bif.alu_y, m_ay);
                check("alu_sel", bif.alu_sel, m_as);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        exp_t       e;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        int         g;
        g = 0;
        @(negedge clk);
        while (!bif.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bif.cmd_ready) begin
            check("accept_timeout", bif.cmd_ready, 1);
            return;
        end
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_rd    = rd;
        bif.cmd_rs1   = rs1;
        bif.cmd_rs2   = rs2;
        bif.cmd_imm   = imm;
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b0;
        e.acc = cyc;
        e.err = 1'b0;
        e.lat = 1;
        if (!op[2]) begin
            a = m_regs[rs1];
            b = m_regs[rs2];
            case (op[1:0])
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                2'b10:   r = a & b;
                default: r = a | b;
            endcase
            m_regs[rd] = r;
            m_flag = (r == 8'h00);
            m_ax = a;
            m_ay = b;
            m_as = op[1:0];
            e.lat = 3;
            e.data = r;
        end else if (op == 3'b100) begin
            m_regs[rd] = imm;
            e.data = imm;
        end else if (op == 3'b101) begin
            e.data = m_regs[rs1];
        end else begin
            e.err = 1'b1;
            e.data = 8'h00;
        end
        e.zero = !e.err && (e.data == 8'h00);
        e.flag = m_flag;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (!(q.size() == 0 && bif.cmd_ready) && g < 300);
        if (g >= 300) check("idle_timeout", q.size(), 0);
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm);
        issue(op, rd, rs1, rs2, imm);
        wait_idle();
    endtask

    initial begin
        int g;
        total = 0;
        bad = 0;
        chk_en = 1'b0;
        hold = 1'b0;
        force_rdy = 1'b0;
        rst = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_op = 3'b000;
        bif.cmd_rd = 2'd0;
        bif.cmd_rs1 = 2'd0;
        bif.cmd_rs2 = 2'd0;
        bif.cmd_imm = 8'h00;
        last_data = 8'h00;
        last_zero = 1'b0;
        last_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("reset_cmd_ready", bif.cmd_ready, 1);
        check("reset_rsp_valid", bif.rsp_valid, 0);
        check("reset_rsp_data", bif.rsp_data, 8'h00);
        check("reset_rsp_zero", bif.rsp_zero, 0);
        check("reset_flag_zero", bif.flag_zero, 0);
        check("reset_alu_x", bif.alu_x, 8'h00);

        // SUB underflow wraps.
        run(3'b100, 2'd0, 2'd0, 2'd0, 8'h05);
        run(3'b100, 2'd1, 2'd0, 2'd0, 8'h07);
        run(3'b001, 2'd2, 2'd0, 2'd1, 8'h00);
        check("sub_data", last_data, 8'hFE);
        check("sub_zero", last_zero, 0);
        check("sub_flag", bif.flag_zero, 0);
        run(3'b101, 2'd0, 2'd2, 2'd0, 8'h00);
        check("read_r2", last_data, 8'hFE);

        run(3'b100, 2'd0, 2'd0, 2'd0, 8'hF0);
        run(3'b100, 2'd1, 2'd0, 2'd0, 8'h0F);
        run(3'b010, 2'd3, 2'd0, 2'd1, 8'h00);
        check("and_data", last_data, 8'h00);
        check("and_zero", last_zero, 1);
        check("and_flag", bif.flag_zero, 1);
        run(3'b011, 2'd3, 2'd0, 2'd1, 8'h00);
        check("or_data", last_data, 8'hFF);
        check("or_flag", bif.flag_zero, 0);

        // ADD with rd == rs1 == rs2, wrapping to zero.
        run(3'b100, 2'd0, 2'd0, 2'd0, 8'h80);
        run(3'b000, 2'd0, 2'd0, 2'd0, 8'h00);
        check("add_wrap_data", last_data, 8'h00);
        check("add_wrap_zero", last_zero, 1);
        run(3'b101, 2'd0, 2'd0, 2'd0, 8'h00);
        check("read_r0", last_data, 8'h00);

        // Backpressure: response held, a second command must not be taken.
        hold = 1'b1;
        issue(3'b000, 2'd1, 2'd0, 2'd1, 8'h00);
        g = 0;
        while (!bif.rsp_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("hold_seen_valid", bif.rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("hold_rsp_valid", bif.rsp_valid, 1);
            check("hold_rsp_data", bif.rsp_data, 8'h0F);
            check("hold_cmd_ready", bif.cmd_ready, 0);
            bif.cmd_valid = 1'b1;
            bif.cmd_op = 3'b100;
            bif.cmd_rd = 2'd2;
            bif.cmd_imm = 8'hAA;
        end
        bif.cmd_valid = 1'b0;
        hold = 1'b0;
        force_rdy = 1'b1;
        wait_idle();
        force_rdy = 1'b0;
        check("hold_last_data", last_data, 8'h0F);
        run(3'b101, 2'd0, 2'd2, 2'd0, 8'h00);
        check("no_second_accept", last_data, 8'hFE);

        // Illegal opcode leaves r1 and the sticky flag alone.
        run(3'b010, 2'd3, 2'd0, 2'd1, 8'h00);
        run(3'b110, 2'd1, 2'd0, 2'd0, 8'h55);
        check("illegal_err", last_err, 1);
        check("illegal_data", last_data, 8'h00);
        check("illegal_err_cleared", bif.rsp_err, 0);
        check("illegal_flag_kept", bif.flag_zero, 1);
        run(3'b101, 2'd0, 2'd1, 2'd0, 8'h00);
        check("illegal_r1_kept", last_data, 8'h0F);

        // Reset while ADD into r2 is in EXEC.
        issue(3'b000, 2'd2, 2'd1, 2'd1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("midrst_rsp_valid", bif.rsp_valid, 0);
        check("midrst_cmd_ready", bif.cmd_ready, 1);
        check("midrst_flag", bif.flag_zero, 0);
        for (int i = 0; i < 4; i++) begin
            run(3'b101, 2'd0, 2'(i), 2'd0, 8'h00);
            check("midrst_reg", last_data, 8'h00);
        end

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
